// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } fetch_state_e;

    localparam int          FETCH_DEPTH = 2;
    localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        misalign;
    } fetch_entry_t;

    // Instruction memory is word addressed; the low PC bits are dropped.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_if.sv
// Instruction-memory request/response and decode-side instruction handshake.
interface fetch_if;

    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;

    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic        instr_misalign_o;

    // Fetch unit side.
    modport master (
        output imem_req_o, imem_addr_o,
        input  imem_gnt_i, imem_rvalid_i, imem_rdata_i,
        output instr_o, instr_pc_o, instr_valid_o, instr_misalign_o,
        input  instr_ready_i
    );

    // Memory and decode side.
    modport slave (
        input  imem_req_o, imem_addr_o,
        output imem_gnt_i, imem_rvalid_i, imem_rdata_i,
        input  instr_o, instr_pc_o, instr_valid_o, instr_misalign_o,
        output instr_ready_i
    );

endinterface

// File: rtl/fetch_fifo.sv
// Two-entry instruction buffer; clear empties it and overrides a same-cycle pop.
module fetch_fifo
    import fetch_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clear_i,
    input  logic         push_i,
    input  fetch_entry_t push_data_i,
    input  logic         pop_i,
    output logic [1:0]   count_o,
    output fetch_entry_t head_o
);

    logic         wptr_q, wptr_d;
    logic         rptr_q, rptr_d;
    logic [1:0]   count_q, count_d;
    logic         do_pop;
    fetch_entry_t mem_q [FETCH_DEPTH];
    fetch_entry_t mem_d [FETCH_DEPTH];

    // Next pointer/count/storage; a pop on an empty buffer is ignored.
    always_comb begin
        mem_d   = mem_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        do_pop  = pop_i && (count_q != 2'd0);
        if (clear_i) begin
            wptr_d  = 1'b0;
            rptr_d  = 1'b0;
            count_d = 2'd0;
        end else begin
            if (push_i) begin
                mem_d[wptr_q] = push_data_i;
                wptr_d        = ~wptr_q;
            end
            if (do_pop) begin
                rptr_d = ~rptr_q;
            end
            case ({push_i, do_pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    // Control state with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q  <= 1'b0;
            rptr_q  <= 1'b0;
            count_q <= 2'd0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Entry storage needs no reset: it is only observed through count.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

    assign count_o = count_q;
    assign head_o  = mem_q[rptr_q];

    // The fetch FSM only issues while a slot is free, so a full-buffer push is a bug.
    a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
        !(push_i && count_q == 2'(FETCH_DEPTH)));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding memory read, kill tracking on redirect,
// responses buffered in a two-entry FIFO towards decode.
module fetch_unit
    import fetch_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] pc_i,
    input  logic        flush_i,
    output logic        pc_stall_o,
    fetch_if.master     bus
);

    fetch_state_e state_q, state_d;
    logic [31:0]  addr_q, addr_d;
    logic         kill_q, kill_d;
    logic         stall;
    logic         req;
    logic         push;
    logic         pop;
    logic         valid;
    logic [1:0]   count;
    fetch_entry_t head;
    fetch_entry_t push_entry;

    assign push_entry = '{instr:    bus.imem_rdata_i,
                          pc:       addr_q,
                          misalign: (addr_q[1:0] != 2'b00)};

    // Fetch FSM: capture PC, hold request until grant, await response.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        kill_d  = kill_q;
        stall   = 1'b1;
        req     = 1'b0;
        push    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (count < 2'(FETCH_DEPTH) && !flush_i) begin
                    addr_d  = pc_i;
                    stall   = 1'b0;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                req = 1'b1;
                // The request cannot be withdrawn, so a redirect marks it stale.
                if (flush_i) kill_d = 1'b1;
                if (bus.imem_gnt_i) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (bus.imem_rvalid_i) begin
                    push    = !kill_q && !flush_i;
                    kill_d  = 1'b0;
                    state_d = S_IDLE;
                end else if (flush_i) begin
                    kill_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM, captured address and kill flag registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            addr_q  <= 32'd0;
            kill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            kill_q  <= kill_d;
        end
    end

    fetch_fifo u_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .clear_i     (flush_i),
        .push_i      (push),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .count_o     (count),
        .head_o      (head)
    );

    // Outputs are held quiet while reset is applied, before the state has settled.
    assign valid                = (count != 2'd0) && !rst_i;
    assign pop                  = valid && bus.instr_ready_i;
    assign pc_stall_o           = stall || rst_i;
    assign bus.imem_req_o       = req && !rst_i;
    assign bus.imem_addr_o      = rst_i ? 32'd0 : word_align(addr_q);
    assign bus.instr_valid_o    = valid;
    assign bus.instr_o          = valid ? head.instr : NOP_INSTR;
    assign bus.instr_pc_o       = valid ? head.pc : 32'd0;
    assign bus.instr_misalign_o = valid && head.misalign;

endmodule
